alu_issue_unit: RTL and testbench



---
 rtl/alu_issue_unit_pkg.sv | 31 +++
 rtl/alu_issue_unit_alu.sv | 40 ++++
 rtl/alu_issue_unit_regfile.sv | 43 ++++
 rtl/alu_issue_unit.sv | 219 +++++++++++++++++++++
 tb/tb_alu_issue_unit.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_unit_pkg.sv
// Shared constants and types for the ALU issue unit: ALU opcodes, RV32I major
// opcodes and the issue FSM state encoding.
package alu_issue_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 4;

    localparam logic [OPW-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OPW-1:0] ALU_SLL  = 4'b0001;
    localparam logic [OPW-1:0] ALU_SLT  = 4'b0010;
    localparam logic [OPW-1:0] ALU_SLTU = 4'b0011;
    localparam logic [OPW-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OPW-1:0] ALU_SRL  = 4'b0101;
    localparam logic [OPW-1:0] ALU_OR   = 4'b0110;
    localparam logic [OPW-1:0] ALU_AND  = 4'b0111;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b1000;
    localparam logic [OPW-1:0] ALU_SRA  = 4'b1101;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_issue_unit_alu.sv
// 32-bit combinational ALU; carry is the carry-out of A+B (add) or A+~B+1 (sub).
module alu_issue_unit_alu
    import alu_issue_unit_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [OPW-1:0]  op,
    output logic [XLEN-1:0] f_c,
    output logic            zf_c,
    output logic            cf_c,
    output logic            of_c,
    output logic            sf_c
);

    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;

    always_comb begin
        b_eff = (op == ALU_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + (XLEN+1)'(op == ALU_SUB);
        f_c   = '0;
        case (op)
            ALU_ADD, ALU_SUB: f_c = sum[XLEN-1:0];
            ALU_SLL:          f_c = a << b[4:0];
            ALU_SLT:          f_c = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:         f_c = XLEN'(a < b);
            ALU_XOR:          f_c = a ^ b;
            ALU_SRL:          f_c = a >> b[4:0];
            ALU_OR:           f_c = a | b;
            ALU_AND:          f_c = a & b;
            ALU_SRA:          f_c = $unsigned($signed(a) >>> b[4:0]);
            default:          f_c = '0;
        endcase
        zf_c = (f_c == '0);
        sf_c = f_c[XLEN-1];
        cf_c = sum[XLEN];
        of_c = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    end

endmodule

// File: rtl/alu_issue_unit_regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one write
// port. x0 is never written, so it always reads zero.
module alu_issue_unit_regfile
    import alu_issue_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] rs1_data_c,
    output logic [XLEN-1:0] rs2_data_c,
    output logic [XLEN-1:0] dbg_data_c,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rs1_data_c = regs_q[rs1_addr];
    assign rs2_data_c = regs_q[rs2_addr];
    assign dbg_data_c = regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Execute-stage issue unit: accepts one RV32I OP/OP-IMM instruction, reads the
// register file, runs the ALU and writes back over a fixed IDLE/RD/EX/WB sequence.
module alu_issue_unit
    import alu_issue_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    output logic            out_valid,
    output logic [AW-1:0]   out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_zf,
    output logic            out_cf,
    output logic            out_of,
    output logic            out_sf,
    output logic            out_illegal,
    input  logic [AW-1:0]   dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    state_e state_q, state_d;

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]  op_q, op_d;
    logic            legal_q, legal_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   out_rd_q, out_rd_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic            out_zf_q, out_zf_d, out_cf_q, out_cf_d;
    logic            out_of_q, out_of_d, out_sf_q, out_sf_d;
    logic            out_illegal_q, out_illegal_d;
    logic            we_c;

    logic [6:0]      f_opc;
    logic [AW-1:0]   f_rd, f_rs1, f_rs2;
    logic [2:0]      f_f3;
    logic [6:0]      f_f7;
    logic [11:0]     f_imm;
    logic            is_op, is_imm, is_shift;
    logic [OPW-1:0]  op_dec;
    logic            legal_dec;
    logic [XLEN-1:0] b_raw;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [XLEN-1:0] alu_f;
    logic            alu_zf, alu_cf, alu_of, alu_sf;

    assign f_opc = instr_q[6:0];
    assign f_rd  = instr_q[11:7];
    assign f_f3  = instr_q[14:12];
    assign f_rs1 = instr_q[19:15];
    assign f_rs2 = instr_q[24:20];
    assign f_f7  = instr_q[31:25];
    assign f_imm = instr_q[31:20];

    // Decode of the latched instruction, consumed during RD.
    always_comb begin
        is_op    = (f_opc == OPC_OP);
        is_imm   = (f_opc == OPC_OPIMM);
        is_shift = (f_f3 == 3'b001) || (f_f3 == 3'b101);
        if (is_op) begin
            op_dec = {f_f7[5], f_f3};
        end else if (f_f3 == 3'b101) begin
            op_dec = {f_imm[10], 3'b101};
        end else begin
            op_dec = {1'b0, f_f3};
        end
        b_raw     = is_op ? rs2_data : {{(XLEN-12){f_imm[11]}}, f_imm};
        legal_dec = 1'b0;
        if (is_op) begin
            legal_dec = (f_f7 == 7'b0000000) ||
                        ((f_f7 == 7'b0100000) && ((f_f3 == 3'b000) || (f_f3 == 3'b101)));
        end else if (is_imm) begin
            case (f_f3)
                3'b001:  legal_dec = (f_f7 == 7'b0000000);
                3'b101:  legal_dec = (f_f7 == 7'b0000000) || (f_f7 == 7'b0100000);
                default: legal_dec = 1'b1;
            endcase
        end
    end

    alu_issue_unit_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (f_rs1),
        .rs2_addr   (f_rs2),
        .dbg_addr   (dbg_raddr),
        .rs1_data_c (rs1_data),
        .rs2_data_c (rs2_data),
        .dbg_data_c (dbg_rdata),
        .we         (we_c),
        .waddr      (out_rd_q),
        .wdata      (out_result_q)
    );

    alu_issue_unit_alu u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .f_c  (alu_f),
        .zf_c (alu_zf),
        .cf_c (alu_cf),
        .of_c (alu_of),
        .sf_c (alu_sf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RD;
            ST_RD:   state_d = ST_EX;
            ST_EX:   state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state datapath and output register updates.
    always_comb begin
        instr_d       = instr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        legal_d       = legal_q;
        out_rd_d      = out_rd_q;
        out_result_d  = out_result_q;
        out_zf_d      = out_zf_q;
        out_cf_d      = out_cf_q;
        out_of_d      = out_of_q;
        out_sf_d      = out_sf_q;
        out_illegal_d = out_illegal_q;
        we_c          = 1'b0;
        in_ready_d    = (state_d == ST_IDLE);
        out_valid_d   = (state_d == ST_WB);
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    instr_d = instr;
                end
            end
            ST_RD: begin
                a_d     = rs1_data;
                b_d     = is_shift ? {{(XLEN-5){1'b0}}, b_raw[4:0]} : b_raw;
                op_d    = op_dec;
                legal_d = legal_dec;
            end
            ST_EX: begin
                out_rd_d      = f_rd;
                out_illegal_d = !legal_q;
                out_result_d  = legal_q ? alu_f : '0;
                out_zf_d      = legal_q && alu_zf;
                out_sf_d      = legal_q && alu_sf;
                // Carry/overflow are only meaningful for the adder ops.
                out_cf_d      = legal_q && alu_cf && ((op_q == ALU_ADD) || (op_q == ALU_SUB));
                out_of_d      = legal_q && alu_of && ((op_q == ALU_ADD) || (op_q == ALU_SUB));
            end
            ST_WB: begin
                we_c = legal_q && (out_rd_q != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            legal_q       <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_result_q  <= '0;
            out_zf_q      <= 1'b0;
            out_cf_q      <= 1'b0;
            out_of_q      <= 1'b0;
            out_sf_q      <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            instr_q       <= instr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            legal_q       <= legal_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_result_q  <= out_result_d;
            out_zf_q      <= out_zf_d;
            out_cf_q      <= out_cf_d;
            out_of_q      <= out_of_d;
            out_sf_q      <= out_sf_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_rd      = out_rd_q;
    assign out_result  = out_result_q;
    assign out_zf      = out_zf_q;
    assign out_cf      = out_cf_q;
    assign out_of      = out_of_q;
    assign out_sf      = out_sf_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed RV32I sequence, mid-operation
// reset, then randomized instructions against an architectural model.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_zf, out_cf, out_of, out_sf, out_illegal;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mdl [32];

    always #5 clk = ~clk;

    alu_issue_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_rd      (out_rd),
        .out_result  (out_result),
        .out_zf      (out_zf),
        .out_cf      (out_cf),
        .out_of      (out_of),
        .out_sf      (out_sf),
        .out_illegal (out_illegal),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Architectural model: result and flags of one instruction from the model state.
    function automatic void model(input logic [31:0] ins, output logic legal,
                                  output logic [31:0] res, output logic zf,
                                  output logic cf, output logic vf, output logic sf);
        logic [6:0]  opc = ins[6:0];
        logic [2:0]  f3  = ins[14:12];
        logic [6:0]  f7  = ins[31:25];
        logic [31:0] a   = mdl[ins[19:15]];
        logic [31:0] b;
        logic [4:0]  sh;
        bit          is_sub = 0;
        bit          alt    = 0;
        longint      s;
        legal = 0;
        res = 0; zf = 0; cf = 0; vf = 0; sf = 0;
        if (opc == 7'b0110011) begin
            b = mdl[ins[24:20]];
            if (f7 == 7'h00) legal = 1;
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin legal = 1; alt = 1; end
        end else if (opc == 7'b0010011) begin
            b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            else if (f3 == 3'd5) begin
                legal = (f7 == 7'h00) || (f7 == 7'h20);
                alt = (f7 == 7'h20);
            end else legal = 1;
        end else begin
            b = 0;
        end
        if (!legal) return;
        sh = b[4:0];
        case (f3)
            3'd0: begin
                is_sub = alt;
                if (is_sub) begin
                    res = a - b;
                    cf  = (a >= b);
                    s   = longint'($signed(a)) - longint'($signed(b));
                end else begin
                    res = a + b;
                    cf  = ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
                    s   = longint'($signed(a)) + longint'($signed(b));
                end
                vf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: res = a << sh;
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = alt ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'd6: res = a | b;
            default: res = a & b;
        endcase
        zf = (res == 0);
        sf = res[31];
    endfunction

    // Issue one instruction and check the whole 4-cycle sequence.
    task automatic issue(input logic [31:0] ins, input bit poke);
        logic legal, ez, ec, eo, es;
        logic [31:0] er;
        logic [4:0]  rd = ins[11:7];
        model(ins, legal, er, ez, ec, eo, es);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1; instr = ins;
        @(posedge clk); #1;
        check("rd_ready", in_ready, 0);
        check("rd_valid", out_valid, 0);
        in_valid = poke; instr = $urandom;
        @(posedge clk); #1;
        check("ex_ready", in_ready, 0);
        check("ex_valid", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 0;
        check("wb_valid", out_valid, 1);
        check("wb_ready", in_ready, 0);
        check("out_rd", out_rd, rd);
        check("out_result", out_result, er);
        check("out_illegal", out_illegal, !legal);
        check("flags", {out_zf, out_cf, out_of, out_sf}, {ez, ec, eo, es});
        @(posedge clk); #1;
        check("idle_valid", out_valid, 0);
        check("idle_ready", in_ready, 1);
        check("hold_result", out_result, er);
        if (legal && rd != 0) mdl[rd] = er;
        dbg_raddr = rd; #1;
        check("dbg_rd", dbg_rdata, mdl[rd]);
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned r = $urandom_range(0, 9);
        logic [4:0]  rd  = 5'($urandom_range(0, 31));
        logic [4:0]  rs1 = 5'($urandom_range(0, 31));
        logic [4:0]  rs2 = 5'($urandom_range(0, 31));
        logic [2:0]  f3  = 3'($urandom_range(0, 7));
        logic [6:0]  f7;
        logic [11:0] imm = 12'($urandom);
        int unsigned p = $urandom_range(0, 19);
        f7 = (p < 13) ? 7'h00 : (p < 18) ? 7'h20 : 7'($urandom);
        if (r < 4) return enc_r(f7, rs2, rs1, f3, rd);
        if (r < 8) begin
            if (f3 == 3'd1 || f3 == 3'd5) imm = {f7, imm[4:0]};
            return enc_i(imm, rs1, f3, rd);
        end
        return $urandom;
    endfunction

    initial begin
        rst_n = 0; in_valid = 0; instr = 0; dbg_raddr = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        #12;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_outs", {27'b0, out_rd}, 0);
        check("rst_flags", {out_zf, out_cf, out_of, out_sf, out_illegal}, 0);
        @(negedge clk); rst_n = 1;

        issue(32'h0050_0093, 0);
        check("addi_x1_const", out_result, 32'd5);
        issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd2), 0);
        issue(32'h0020_81B3, 1);
        check("add_const", {out_result[7:0], 3'b0, out_cf, out_of}, {8'd4, 5'b00010});
        issue(32'h4010_8233, 0);
        check("sub_zf", out_zf, 1);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd8), 1);
        check("slt_const", out_result, 32'd1);
        issue(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd9), 0);
        check("sltu_const", out_result, 32'd0);
        issue(enc_i(12'd36, 5'd0, 3'd0, 5'd6), 0);
        issue(32'h4061_52B3, 1);
        check("sra_const", out_result, 32'hFFFF_FFFF);
        issue(enc_i(12'd4, 5'd2, 3'd5, 5'd7), 0);
        check("srli_const", out_result, 32'h0FFF_FFFF);
        issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 1);
        check("x0_result", out_result, 32'd7);
        issue(32'h0000_0000, 0);
        check("illegal_const", out_illegal, 1);

        // Reset during EX of an add: nothing completes, state clears.
        @(negedge clk);
        in_valid = 1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10);
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0; #1;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        @(negedge clk); @(negedge clk); rst_n = 1;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("abort_no_valid", out_valid, 0);
        end
        check("abort_ready_after", in_ready, 1);
        dbg_raddr = 5'd10; #1;
        check("abort_no_write", dbg_rdata, 0);

        for (int i = 1; i < 32; i++) issue(enc_i(12'($urandom), 5'd0, 3'd0, 5'(i)), 0);
        for (int n = 0; n < 300; n++) issue(rand_instr(), 1'($urandom));
        for (int i = 0; i < 32; i++) begin
            dbg_raddr = 5'(i); #1;
            check("final_reg", dbg_rdata, mdl[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
